// File: rtl/pipe_stage_hs.sv
// Pipeline-boundary register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush that leaves a bubble, and a saturating bubble counter.
module pipe_stage_hs #(
  parameter int unsigned       DATA_W      = 32,
  parameter bit                SKID        = 1'b1,
  parameter logic [DATA_W-1:0] NOP_VAL     = '0,
  parameter bit                BUBBLE_ZERO = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              count_clr,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_xfer, out_xfer;

  assign out_valid    = (state_q != EMPTY);
  // Without a skid entry, readiness must follow out_ready in the same cycle.
  assign in_ready     = SKID ? rdy_q : (out_ready | ~out_valid);
  assign in_xfer      = in_valid & in_ready;
  assign out_xfer     = out_valid & out_ready;
  assign out_data     = main_q;
  assign bubble_count = cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // Older payload is in main; the parked one moves up so order stays FIFO.
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    if (BUBBLE_ZERO && (state_d == EMPTY)) begin
      main_d = NOP_VAL;
    end
  end

  always_comb begin
    rdy_d = (state_d != TWO);
    cnt_d = cnt_q;
    if (count_clr) begin
      cnt_d = '0;
    end else if (!out_valid && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Skid payload is only meaningful while state is TWO, so it needs no reset.
  always_ff @(posedge clock) begin
    skid_q <= skid_d;
  end

endmodule
